// File: rtl/axi_light_prio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_light_prio_arbiter_pkg
//
// Shared types and helpers for the N-port priority arbiter:
//   - arb_state_t     : arbiter FSM state encoding
//   - gid_width()     : width of a port index (grant id, round-robin pointer)
//   - eff_prio_width(): width of the effective priority (one extra bit so an
//                       aged port can rank above every native priority level)
// -----------------------------------------------------------------------------
package axi_light_prio_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } arb_state_t;

    function automatic int gid_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    function automatic int eff_prio_width(input int prio_w);
        return prio_w + 1;
    endfunction

endpackage

// File: rtl/axi_light_prio_arbiter_pick.sv
// -----------------------------------------------------------------------------
// prio_rr_pick
//
// Combinational winner selection. Among the valid ports, find the highest
// effective priority; among the ports tied at that level, pick the first one
// at or after rr_ptr, wrapping around to port 0.
//
// Ports:
//   valid     in  N_PORTS          candidate request valid bits
//   eff_prio  in  N_PORTS*EP_W     effective priority per port
//   rr_ptr    in  GID_W            round-robin start position
//   winner    out GID_W            selected port (0 when nothing is valid)
//   any_valid out 1                at least one candidate is valid
// -----------------------------------------------------------------------------
module prio_rr_pick
    import axi_light_prio_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int EP_W    = 3,
    parameter int GID_W   = gid_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0]      valid,
    input  logic [N_PORTS*EP_W-1:0] eff_prio,
    input  logic [GID_W-1:0]        rr_ptr,
    output logic [GID_W-1:0]        winner,
    output logic                    any_valid
);

    logic [EP_W-1:0]    max_prio;
    logic [N_PORTS-1:0] tied;
    logic               found_hi;
    logic               found_lo;
    logic [GID_W-1:0]   win_hi;
    logic [GID_W-1:0]   win_lo;

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path can leave it holding a value (which infers a latch).
        max_prio = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (valid[i] && (eff_prio[i*EP_W +: EP_W] > max_prio)) begin
                max_prio = eff_prio[i*EP_W +: EP_W];
            end
        end
    end

    always_comb begin
        tied = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            tied[i] = valid[i] && (eff_prio[i*EP_W +: EP_W] == max_prio);
        end
    end

    // Wrap-around search done as two scans: first tied port at/after rr_ptr,
    // otherwise the first tied port from index 0.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (tied[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = GID_W'(i);
            end
            if (tied[i] && !found_hi && (GID_W'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                win_hi   = GID_W'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    assign any_valid = |valid;

endmodule

// File: rtl/axi_light_prio_arbiter.sv
// -----------------------------------------------------------------------------
// axi_light_prio_arbiter
//
// N-port front end for the memory controller's priority AXI-light slave port.
// Highest effective priority wins, round-robin among ties; one transaction is
// outstanding at a time and its response is routed back to the granted port.
//
// Optional feature macro: ARB_AGING_EN
//   defined   : per-port saturating wait counters; a saturated port ranks
//               above every native priority level.
//   undefined : no counters; effective priority equals m_req_prio.
//
// Ports:
//   clk, res                     clock, asynchronous active-high reset
//   m_req_valid/ready/we         per-port request handshake and write enable
//   m_req_prio/addr/wdata        per-port packed payload
//   m_rsp_valid/ready            per-port response handshake
//   m_rsp_rdata                  shared registered read data
//   s_req_valid/ready            request handshake to the slave
//   s_req_we/addr/wdata          registered request to the slave
//   s_rsp_valid/rdata            slave response
//   grant_id                     index of the current or last grant
// -----------------------------------------------------------------------------
module axi_light_prio_arbiter
    import axi_light_prio_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIO_W  = 2,
    parameter int AGE_W   = 4
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [N_PORTS-1:0]            m_req_valid,
    output logic [N_PORTS-1:0]            m_req_ready,
    input  logic [N_PORTS-1:0]            m_req_we,
    input  logic [N_PORTS*PRIO_W-1:0]     m_req_prio,
    input  logic [N_PORTS*ADDR_W-1:0]     m_req_addr,
    input  logic [N_PORTS*DATA_W-1:0]     m_req_wdata,
    output logic [N_PORTS-1:0]            m_rsp_valid,
    input  logic [N_PORTS-1:0]            m_rsp_ready,
    output logic [DATA_W-1:0]             m_rsp_rdata,
    output logic                          s_req_valid,
    input  logic                          s_req_ready,
    output logic                          s_req_we,
    output logic [ADDR_W-1:0]             s_req_addr,
    output logic [DATA_W-1:0]             s_req_wdata,
    input  logic                          s_rsp_valid,
    input  logic [DATA_W-1:0]             s_rsp_rdata,
    output logic [gid_width(N_PORTS)-1:0] grant_id
);

    localparam int GID_W = gid_width(N_PORTS);
    localparam int EP_W  = eff_prio_width(PRIO_W);

    arb_state_t               state;
    arb_state_t               state_nxt;
    logic [GID_W-1:0]         rr_ptr;
    logic [GID_W-1:0]         winner;
    logic                     any_valid;
    logic                     grant;
    logic                     rsp_capture;
    logic [N_PORTS*EP_W-1:0]  eff_prio;
    logic                     sel_we;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;

    assign grant       = (state == IDLE) && any_valid;
    assign rsp_capture = s_rsp_valid &&
                         ((state == WAIT_RSP) || ((state == ISSUE) && s_req_ready));

    // ------------------------------------------------------------------
    // Effective priority
    // ------------------------------------------------------------------
`ifdef ARB_AGING_EN
    logic [AGE_W-1:0] age [N_PORTS];

    // NOTE: this small counter array is reset explicitly because the
    // saturation rule depends on it starting from zero; large data storage
    // would normally be left unreset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < N_PORTS; i++) begin
                age[i] <= '0;
            end
        end else if (state == IDLE) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!m_req_valid[i] || (grant && (winner == GID_W'(i)))) begin
                    age[i] <= '0;
                end else if (age[i] != '1) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // A saturated port is lifted to 2^PRIO_W, one level above any native value.
    always_comb begin
        eff_prio = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            eff_prio[i*EP_W +: EP_W] = (age[i] == '1) ? {1'b1, {PRIO_W{1'b0}}}
                                                      : {1'b0, m_req_prio[i*PRIO_W +: PRIO_W]};
        end
    end
`else
    // Keeps AGE_W referenced in builds without aging.
    logic [AGE_W-1:0] unused_age;
    assign unused_age = '0;

    always_comb begin
        eff_prio = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            eff_prio[i*EP_W +: EP_W] = {1'b0, m_req_prio[i*PRIO_W +: PRIO_W]};
        end
    end
`endif

    prio_rr_pick #(
        .N_PORTS (N_PORTS),
        .EP_W    (EP_W),
        .GID_W   (GID_W)
    ) u_pick (
        .valid     (m_req_valid),
        .eff_prio  (eff_prio),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_valid) state_nxt = ISSUE;
            ISSUE:    if (s_req_ready) state_nxt = s_rsp_valid ? RESPOND : WAIT_RSP;
            WAIT_RSP: if (s_rsp_valid) state_nxt = RESPOND;
            RESPOND:  if (m_rsp_ready[grant_id]) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // m_req_ready is a same-cycle combinational grant; it is masked by res so
    // all outputs drop immediately even while a requester holds valid.
    always_comb begin
        m_req_ready = '0;
        m_rsp_valid = '0;
        s_req_valid = 1'b0;
        case (state)
            IDLE:    if (any_valid && !res) m_req_ready[winner] = 1'b1;
            ISSUE:   s_req_valid = 1'b1;
            RESPOND: m_rsp_valid[grant_id] = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Payload mux and registered datapath
    // ------------------------------------------------------------------
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (winner == GID_W'(i)) begin
                sel_we    = m_req_we[i];
                sel_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            s_req_we    <= 1'b0;
            s_req_addr  <= '0;
            s_req_wdata <= '0;
            m_rsp_rdata <= '0;
        end else begin
            if (grant) begin
                grant_id    <= winner;
                rr_ptr      <= (winner == GID_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
                s_req_we    <= sel_we;
                s_req_addr  <= sel_addr;
                s_req_wdata <= sel_wdata;
            end
            // Write responses carry no data; keep the last read value instead.
            if (rsp_capture && !s_req_we) begin
                m_rsp_rdata <= s_rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_light_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_light_prio_arbiter
//
// Self-checking bench for axi_light_prio_arbiter (N_PORTS=4, AGE_W=2).
// Expected grants come from a small reference model of the arbitration rule;
// expected responses are pushed to a scoreboard queue at grant time and
// popped when the DUT raises m_rsp_valid. The slave returns addr + 0x1000.
// -----------------------------------------------------------------------------
module tb_axi_light_prio_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int PW  = 2;
    localparam int AGW = 2;

    logic            clk = 1'b0;
    logic            res;
    logic [N-1:0]    m_req_valid;
    logic [N-1:0]    m_req_ready;
    logic [N-1:0]    m_req_we;
    logic [N*PW-1:0] m_req_prio;
    logic [N*AW-1:0] m_req_addr;
    logic [N*DW-1:0] m_req_wdata;
    logic [N-1:0]    m_rsp_valid;
    logic [N-1:0]    m_rsp_ready;
    logic [DW-1:0]   m_rsp_rdata;
    logic            s_req_valid;
    logic            s_req_ready;
    logic            s_req_we;
    logic [AW-1:0]   s_req_addr;
    logic [DW-1:0]   s_req_wdata;
    logic            s_rsp_valid;
    logic [DW-1:0]   s_rsp_rdata;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi_light_prio_arbiter #(
        .N_PORTS (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .PRIO_W  (PW),
        .AGE_W   (AGW)
    ) dut (
        .clk         (clk),
        .res         (res),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_we    (m_req_we),
        .m_req_prio  (m_req_prio),
        .m_req_addr  (m_req_addr),
        .m_req_wdata (m_req_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_ready (m_rsp_ready),
        .m_rsp_rdata (m_rsp_rdata),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_we    (s_req_we),
        .s_req_addr  (s_req_addr),
        .s_req_wdata (s_req_wdata),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_rdata (s_rsp_rdata),
        .grant_id    (grant_id)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        bit            is_read;
    } exp_rsp_t;

    exp_rsp_t sb[$];
    int       m_rr;
    int       m_age[N];

    function automatic int eff_lvl(input int p);
`ifdef ARB_AGING_EN
        if (m_age[p] == (1 << AGW) - 1) return 1 << PW;
`endif
        return int'(m_req_prio[p*PW +: PW]);
    endfunction

    function automatic int model_pick();
        for (int lvl = (1 << PW); lvl >= 0; lvl--) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_rr + k) % N;
                if (m_req_valid[p] && eff_lvl(p) == lvl) return p;
            end
        end
        return -1;
    endfunction

    function automatic void model_update(input int w);
        for (int i = 0; i < N; i++) begin
            if (!m_req_valid[i] || i == w) m_age[i] = 0;
            else if (m_age[i] < (1 << AGW) - 1) m_age[i]++;
        end
        m_rr = (w + 1) % N;
    endfunction

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return a + 32'h0000_1000;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int p, input int prio, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic we);
        m_req_valid[p]          = 1'b1;
        m_req_prio[p*PW +: PW]  = PW'(prio);
        m_req_addr[p*AW +: AW]  = a;
        m_req_wdata[p*DW +: DW] = d;
        m_req_we[p]             = we;
    endtask

    task automatic clear_reqs();
        m_req_valid = '0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    task automatic apply_reset();
        res         = 1'b1;
        m_req_valid = '0;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        m_rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        sb.delete();
    endtask

    int            last_port;
    int            last_gcyc;
    int            last_rcyc;
    logic [DW-1:0] last_rdata;

    // One full transaction starting in IDLE (called at posedge+1 with the
    // requests already driven). Returns at posedge+1 of the next IDLE cycle.
    task automatic do_txn(input int req_wait, input bit rsp_same, input int rsp_hold, input bit drop);
        int            exp_w;
        int            waited;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
        exp_rsp_t      e;
        #1;
        exp_w     = model_pick();
        last_port = -1;
        for (int i = 0; i < N; i++) if (m_req_ready[i]) last_port = i;
        last_gcyc = cyc;
        check("ready_onehot", $countones(m_req_ready), 1);
        check("grant_port", last_port, exp_w);
        if (exp_w < 0) return;
        a  = m_req_addr[exp_w*AW +: AW];
        d  = m_req_wdata[exp_w*DW +: DW];
        we = m_req_we[exp_w];
        sb.push_back('{exp_w, slave_data(a), !we});
        model_update(exp_w);

        @(posedge clk); #1;
        if (drop) m_req_valid[exp_w] = 1'b0;
        check("s_req_valid", s_req_valid, 1);
        check("s_req_addr", s_req_addr, a);
        check("s_req_we", s_req_we, we);
        if (we) check("s_req_wdata", s_req_wdata, d);
        check("grant_id", grant_id, exp_w);
        check("ready_outside_idle", m_req_ready, 0);
        for (int c = 0; c < req_wait; c++) begin
            @(posedge clk); #1;
            check("issue_hold_valid", s_req_valid, 1);
            check("issue_hold_addr", s_req_addr, a);
        end
        s_req_ready = 1'b1;
        s_rsp_valid = rsp_same;
        s_rsp_rdata = slave_data(s_req_addr);
        @(posedge clk); #1;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        if (!rsp_same) begin
            s_rsp_valid = 1'b1;
            s_rsp_rdata = slave_data(s_req_addr);
            @(posedge clk); #1;
            s_rsp_valid = 1'b0;
        end

        waited = 0;
        while (m_rsp_valid == '0 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        last_rcyc  = cyc;
        last_rdata = m_rsp_rdata;
        e = sb.pop_front();
        check("rsp_seen", |m_rsp_valid, 1);
        if (m_rsp_valid == '0) return;
        check("rsp_port", m_rsp_valid, 64'(1) << e.port);
        if (e.is_read) check("rsp_rdata", m_rsp_rdata, e.rdata);
        for (int h = 0; h < rsp_hold; h++) begin
            @(posedge clk); #1;
            check("rsp_hold_valid", m_rsp_valid, 64'(1) << e.port);
            if (e.is_read) check("rsp_hold_rdata", m_rsp_rdata, e.rdata);
        end
        m_rsp_ready[e.port] = 1'b1;
        @(posedge clk); #1;
        m_rsp_ready = '0;
        check("rsp_done", m_rsp_valid, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int t2_exp[3] = '{1, 3, 0};
    int prev_gcyc;
    int port0_wins;

    initial begin
        m_req_valid = '0;
        m_req_we    = '0;
        m_req_prio  = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_rsp_ready = '0;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = '0;
        apply_reset();

        // Reset state
        check("rst_m_req_ready", m_req_ready, 0);
        check("rst_m_rsp_valid", m_rsp_valid, 0);
        check("rst_m_rsp_rdata", m_rsp_rdata, 0);
        check("rst_s_req_valid", s_req_valid, 0);
        check("rst_s_req_addr", s_req_addr, 0);
        check("rst_grant_id", grant_id, 0);

        // Mixed priorities from rr_ptr=0: 1, 3, then 0
        set_req(0, 1, 32'h1000_0000, 32'h0, 1'b0);
        set_req(1, 3, 32'h1000_0100, 32'h0, 1'b0);
        set_req(3, 3, 32'h1000_0300, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_txn(0, 1'b0, 0, 1'b1);
            check("prio_order", last_port, t2_exp[i]);
        end

        // Single read on port 2, minimum latency
        set_req(2, 1, 32'hDEAD_AEEF, 32'h0, 1'b0);
        do_txn(0, 1'b0, 0, 1'b1);
        check("single_port", last_port, 2);
        check("single_latency", last_rcyc - last_gcyc, 3);
        check("single_rdata", last_rdata, 32'hDEAD_BEEF);
        check("single_grant_id", grant_id, 2);

        // Write on port 1
        set_req(1, 2, 32'h2000_0040, 32'h1234_5678, 1'b1);
        do_txn(0, 1'b0, 0, 1'b1);
        check("write_port", last_port, 1);

        // Equal priorities held valid: strict rotation, 4-cycle spacing
        apply_reset();
        for (int p = 0; p < N; p++) set_req(p, 2, 32'h3000_0000 + 32'(p * 16), 32'h0, 1'b0);
        prev_gcyc = 0;
        for (int i = 0; i < 8; i++) begin
            do_txn(0, 1'b0, 0, 1'b0);
            check("rr_order", last_port, i % N);
            if (i > 0) check("b2b_spacing", last_gcyc - prev_gcyc, 4);
            prev_gcyc = last_gcyc;
        end

        // Slow slave: ready after 5 cycles together with the response,
        // requester holds off m_rsp_ready for 3 cycles
        clear_reqs();
        set_req(3, 0, 32'h4000_0008, 32'h0, 1'b0);
        do_txn(5, 1'b1, 3, 1'b1);
        check("slow_port", last_port, 3);
        check("slow_latency", last_rcyc - last_gcyc, 7);

        // Starvation / aging: port 0 prio 0 vs port 1 prio 3
        apply_reset();
        set_req(0, 0, 32'h5000_0000, 32'h0, 1'b0);
        set_req(1, 3, 32'h5000_0100, 32'h0, 1'b0);
        port0_wins = 0;
`ifdef ARB_AGING_EN
        for (int i = 0; i < 8; i++) begin
            do_txn(0, 1'b0, 0, 1'b0);
            check("aging_order", last_port, ((i % 4) == 3) ? 0 : 1);
            if (last_port == 0) port0_wins++;
        end
        check("aging_port0_wins", port0_wins, 2);
`else
        for (int i = 0; i < 20; i++) begin
            do_txn(0, 1'b0, 0, 1'b0);
            check("starve_port", last_port, 1);
            if (last_port == 0) port0_wins++;
        end
        check("starve_port0_wins", port0_wins, 0);
`endif

        // Reset in WAIT_RSP aborts the transaction
        clear_reqs();
        set_req(3, 1, 32'h6000_0000, 32'hA5A5_A5A5, 1'b0);
        @(posedge clk); #1;
        check("abort_issue", s_req_valid, 1);
        s_req_ready = 1'b1;
        @(posedge clk); #1;
        s_req_ready = 1'b0;
        check("abort_wait_rsp", s_req_valid, 0);
        #2 res = 1'b1;
        #1;
        check("abort_m_req_ready", m_req_ready, 0);
        check("abort_m_rsp_valid", m_rsp_valid, 0);
        check("abort_m_rsp_rdata", m_rsp_rdata, 0);
        check("abort_s_req_valid", s_req_valid, 0);
        check("abort_s_req_addr", s_req_addr, 0);
        check("abort_s_req_wdata", s_req_wdata, 0);
        check("abort_s_req_we", s_req_we, 0);
        check("abort_grant_id", grant_id, 0);
        m_req_valid = '0;
        set_req(0, 1, 32'h7000_0000, 32'h0, 1'b0);
        @(posedge clk); #1;
        res  = 1'b0;
        m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        sb.delete();
        do_txn(0, 1'b0, 0, 1'b1);
        check("post_reset_port", last_port, 0);
        check("post_reset_rdata", last_rdata, 32'h7000_1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
